// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (load-use, redirect, dmem freeze/timeout, stall count)
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             mem_read_ex,
  input  logic [4:0]       num_write_ex,
  input  logic             mem_read_mem,
  input  logic             mem_write_mem,
  input  logic [1:0]       s_npc_mem,
  input  logic             zero_mem,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             redirect,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             acc, hz, taken, err, freeze, go;
  always_comb begin
    acc    = mem_read_mem | mem_write_mem;
    hz     = mem_read_ex & (num_write_ex != 5'd0) &
             ((use_rs_id & (rs_id == num_write_ex)) | (use_rt_id & (rt_id == num_write_ex)));
    taken  = ((s_npc_mem == 2'b01) & zero_mem) | s_npc_mem[1];
    err    = state_q == ERR;
    freeze = acc & ~dmem_ready & ~err;
    // go: pipeline advances at least partially this cycle; outputs forced low while reset is held
    go           = reset & ~err & ~freeze;
    dmem_req     = reset & acc & ~err;
    pc_en        = go & (taken | ~hz);
    if_id_en     = pc_en;
    id_ex_en     = go;
    ex_mem_en    = go;
    if_id_flush  = go & taken;
    ex_mem_flush = go & taken;
    id_ex_flush  = go & (taken | hz);
    redirect     = go & taken;
    mem_wb_flush = reset & (err | freeze);
    mem_err      = err;
    stall_cnt    = stall_cnt_q;
    stall_cnt_d  = (~pc_en && stall_cnt_q != {CNT_W{1'b1}}) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    if (!err) begin
      if (!freeze) begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end else if (state_q == RUN) begin
        state_d    = WAIT;
        wait_cnt_d = WW'(1);
      end else if (wait_cnt_q == WW'(MEM_TIMEOUT - 1)) begin
        state_d    = ERR;
      end else begin
        wait_cnt_d = wait_cnt_q + WW'(1);
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized check of pipe_hazard_ctrl against a cycle-level reference model
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 5;
  logic clock = 0, reset = 0;
  logic [4:0] rs_id, rt_id, num_write_ex;
  logic use_rs_id, use_rt_id, mem_read_ex, mem_read_mem, mem_write_mem, zero_mem, dmem_ready;
  logic [1:0] s_npc_mem;
  logic dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush;
  logic mem_wb_flush, redirect, mem_err;
  logic [CW-1:0] stall_cnt;
  int n_checks = 0, n_errors = 0;
  int m_wait = 0, m_cnt = 0;
  bit m_err = 0;
  logic [10:0] exp_v;
  wire  [10:0] got_v = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                        ex_mem_en, ex_mem_flush, mem_wb_flush, redirect, mem_err};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id),
    .use_rt_id(use_rt_id), .mem_read_ex(mem_read_ex), .num_write_ex(num_write_ex),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .s_npc_mem(s_npc_mem),
    .zero_mem(zero_mem), .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .redirect(redirect), .mem_err(mem_err), .stall_cnt(stall_cnt));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected {req,pc_en,if_id_en,if_id_fl,id_ex_en,id_ex_fl,ex_mem_en,ex_mem_fl,mem_wb_fl,redirect,mem_err}
  function automatic logic [10:0] model_out();
    bit acc   = mem_read_mem | mem_write_mem;
    bit hz    = mem_read_ex && num_write_ex != 0 &&
                ((use_rs_id && rs_id == num_write_ex) || (use_rt_id && rt_id == num_write_ex));
    bit taken = (s_npc_mem == 2'b01 && zero_mem) || s_npc_mem[1];
    if (m_err) return 11'b000_0000_0101;
    if (acc && !dmem_ready) return 11'b100_0000_0100;
    if (taken) return {acc, 10'b11_1111_1010};
    if (hz) return {acc, 10'b00_0111_0000};
    return {acc, 10'b11_0101_0000};
  endfunction

  task automatic idle();
    {rs_id, rt_id, num_write_ex} = '0;
    {use_rs_id, use_rt_id, mem_read_ex, mem_read_mem, mem_write_mem, zero_mem, dmem_ready} = '0;
    s_npc_mem = 2'b00;
  endtask

  task automatic cycle(input string tag);
    @(negedge clock);
    exp_v = model_out();
    check({tag, "_ctl"}, 32'(got_v), 32'(exp_v));
    check({tag, "_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    @(posedge clock);
    if (!exp_v[9]) m_cnt = (m_cnt == 2 ** CW - 1) ? m_cnt : m_cnt + 1;
    if (!m_err) begin
      if (exp_v == 11'b100_0000_0100) begin
        m_wait++;
        if (m_wait == TO) m_err = 1;
      end else m_wait = 0;
    end
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 0;
    m_wait = 0; m_cnt = 0; m_err = 0;
    #1;
    check({tag, "_ctl"}, 32'(got_v), 32'd0);
    check({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
    idle();
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    #12;
    do_reset("rst0");
    // load-use: lw r2 in EX, add r3,r2,r1 in ID
    mem_read_ex = 1; num_write_ex = 5'd2; rs_id = 5'd2; rt_id = 5'd1; use_rs_id = 1; use_rt_id = 1;
    cycle("lu");
    idle();
    cycle("lu_after");
    check("lu_cnt1", 32'(stall_cnt), 32'd1);
    // r0 destination never stalls
    mem_read_ex = 1; num_write_ex = 5'd0; rs_id = 5'd0; use_rs_id = 1;
    cycle("r0");
    idle();
    // branch taken / not taken
    s_npc_mem = 2'b01; zero_mem = 1;
    cycle("br_t");
    zero_mem = 0;
    cycle("br_nt");
    s_npc_mem = 2'b11;
    cycle("jr");
    idle();
    // load in MEM, ready after 3 cycles
    do_reset("rst1");
    mem_read_mem = 1;
    for (int i = 0; i < 3; i++) cycle("frz");
    dmem_ready = 1;
    cycle("frz_done");
    idle();
    cycle("frz_post");
    check("frz_cnt3", 32'(stall_cnt), 32'd3);
    // ready together with a taken branch
    mem_write_mem = 1; dmem_ready = 1; s_npc_mem = 2'b10;
    cycle("rdy_br");
    idle();
    // timeout into ERR, sticky
    mem_read_mem = 1;
    for (int i = 0; i < TO; i++) cycle("to");
    for (int i = 0; i < 3; i++) cycle("err");
    idle();
    cycle("err_idle");
    check("err_sticky", 32'(mem_err), 32'd1);
    do_reset("rst_err");
    check("err_clr", 32'(mem_err), 32'd0);
    // reset mid-access in WAIT
    mem_read_mem = 1;
    cycle("w6a");
    cycle("w6b");
    #2;
    do_reset("rst_wait");
    cycle("post_rst");
    // randomized
    for (int n = 0; n < 3000; n++) begin
      if (m_err && $urandom_range(0, 7) == 0) do_reset("rnd_rst");
      rs_id = 5'($urandom_range(0, 7)); rt_id = 5'($urandom_range(0, 7));
      num_write_ex = 5'($urandom_range(0, 7));
      use_rs_id = 1'($urandom); use_rt_id = 1'($urandom); mem_read_ex = 1'($urandom);
      mem_read_mem = $urandom_range(0, 4) == 0; mem_write_mem = $urandom_range(0, 6) == 0;
      s_npc_mem = 2'($urandom); zero_mem = 1'($urandom);
      dmem_ready = $urandom_range(0, 2) != 0;
      cycle("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
